// File: rtl/seg7_decode_monitor.sv
// rtl/seg7_decode_monitor.sv - 7-segment bus decoder with stability filter, error counter and optional down-sequence check (SEG7_SEQ_CHECK_EN)
module seg7_decode_monitor #(
  parameter int STABLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  input  logic             clear_err,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             pattern_err,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0] STAB    = 4'(STABLE_CYCLES);
  localparam logic [6:0] SEG_BLK = 7'h7F;

  logic [6:0]       r_samp;
  logic [3:0]       r_run;
  logic             r_acc;
  logic [6:0]       r_acc_pat;
  logic [3:0]       r_digit;
  logic             r_digit_valid;
  logic             r_pattern_err;
  logic             r_seq_err;
  logic             r_locked;
  logic [ERR_W-1:0] r_err_count;

  logic       w_changed;
  logic [3:0] w_run_nx;
  logic       w_acc_pre;
  logic       w_hit;
  logic       w_accept;
  logic       w_legal;
  logic       w_blank;
  logic [3:0] w_dec;
  logic       w_valid_nx;
  logic       w_perr_nx;
  logic       w_serr_nx;
  logic       w_inc;

  always_comb begin
    w_legal = 1'b1;
    w_blank = 1'b0;
    w_dec   = 4'h0;
    case (seg_in)
      7'h40: w_dec = 4'h0;
      7'h79: w_dec = 4'h1;
      7'h24: w_dec = 4'h2;
      7'h30: w_dec = 4'h3;
      7'h19: w_dec = 4'h4;
      7'h12: w_dec = 4'h5;
      7'h02: w_dec = 4'h6;
      7'h78: w_dec = 4'h7;
      7'h00: w_dec = 4'h8;
      7'h10: w_dec = 4'h9;
      7'h08: w_dec = 4'hA;
      7'h03: w_dec = 4'hB;
      7'h46: w_dec = 4'hC;
      7'h21: w_dec = 4'hD;
      7'h06: w_dec = 4'hE;
      7'h0E: w_dec = 4'hF;
      SEG_BLK: begin
        w_legal = 1'b0;
        w_blank = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // A glitch that settles back onto the pattern already accepted must not re-accept it.
  always_comb begin
    w_changed = (seg_in != r_samp);
    w_run_nx  = w_changed ? 4'd1 : ((r_run < STAB) ? r_run + 4'd1 : r_run);
    w_acc_pre = w_changed ? 1'b0 : r_acc;
    w_hit     = (w_run_nx == STAB);
    w_accept  = w_hit && !w_acc_pre && (seg_in != r_acc_pat);
  end

  always_comb begin
    w_valid_nx = w_accept && w_legal;
    w_perr_nx  = w_accept && !w_legal && !w_blank;
  end

`ifdef SEG7_SEQ_CHECK_EN
  logic [3:0] w_expect;
  always_comb begin
    w_expect  = r_digit - 4'd1;
    w_serr_nx = w_valid_nx && r_locked && (w_dec != w_expect) && (w_dec != r_digit);
  end
`else
  always_comb begin
    w_serr_nx = 1'b0;
  end
`endif

  assign w_inc = w_perr_nx || w_serr_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_samp    <= SEG_BLK;
      r_run     <= 4'd0;
      r_acc     <= 1'b0;
      r_acc_pat <= SEG_BLK;
    end else begin
      r_samp <= seg_in;
      r_run  <= w_run_nx;
      r_acc  <= w_acc_pre || w_hit;
      if (w_accept) begin
        r_acc_pat <= seg_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_digit       <= 4'h0;
      r_digit_valid <= 1'b0;
      r_pattern_err <= 1'b0;
      r_seq_err     <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      r_digit_valid <= w_valid_nx;
      r_pattern_err <= w_perr_nx;
      r_seq_err     <= w_serr_nx;
      if (w_accept) begin
        r_locked <= w_legal;
        if (w_legal) begin
          r_digit <= w_dec;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_count <= '0;
    end else if (clear_err) begin
      r_err_count <= '0;
    end else if (w_inc && (r_err_count != {ERR_W{1'b1}})) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign digit       = r_digit;
  assign digit_valid = r_digit_valid;
  assign pattern_err = r_pattern_err;
  assign seq_err     = r_seq_err;
  assign locked      = r_locked;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_seg7_decode_monitor.sv
// tb/tb_seg7_decode_monitor.sv - directed bench for seg7_decode_monitor (default and ERR_W=2 instances)
module tb_seg7_decode_monitor;

`ifdef SEG7_SEQ_CHECK_EN
  localparam int SEQ_ON = 1;
`else
  localparam int SEQ_ON = 0;
`endif

  logic       clk;
  logic       reset;
  logic [6:0] seg_in;
  logic       clear_err;

  logic [3:0] digit;
  logic       digit_valid;
  logic       pattern_err;
  logic       seq_err;
  logic       locked;
  logic [7:0] err_count;

  logic [3:0] w2_digit;
  logic       w2_digit_valid;
  logic       w2_pattern_err;
  logic       w2_seq_err;
  logic       w2_locked;
  logic [1:0] w2_err_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_dv = 0;
  int n_pe = 0;
  int n_se = 0;
  int s_dv, s_pe, s_se;

  seg7_decode_monitor #(.STABLE_CYCLES(2), .ERR_W(8)) u_dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .clear_err(clear_err),
    .digit(digit), .digit_valid(digit_valid), .pattern_err(pattern_err),
    .seq_err(seq_err), .locked(locked), .err_count(err_count)
  );

  seg7_decode_monitor #(.STABLE_CYCLES(2), .ERR_W(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .seg_in(seg_in), .clear_err(clear_err),
    .digit(w2_digit), .digit_valid(w2_digit_valid), .pattern_err(w2_pattern_err),
    .seq_err(w2_seq_err), .locked(w2_locked), .err_count(w2_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (digit_valid) n_dv++;
    if (pattern_err) n_pe++;
    if (seq_err) n_se++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_dv = n_dv;
    s_pe = n_pe;
    s_se = n_se;
  endtask

  initial begin
    reset = 1'b0;
    seg_in = 7'h7F;
    clear_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digit", digit, 0);
    check("rst_dv", digit_valid, 0);
    check("rst_perr", pattern_err, 0);
    check("rst_serr", seq_err, 0);
    check("rst_locked", locked, 0);
    check("rst_errcnt", err_count, 0);
    reset = 1'b1;

    snap();
    hold(7'h40, 3);
    check("t1_dv_pulses", n_dv - s_dv, 1);
    check("t1_digit", digit, 0);
    check("t1_locked", locked, 1);
    check("t1_errcnt", err_count, 0);

    snap();
    hold(7'h0E, 4);
    check("t2_digit_F", digit, 15);
    hold(7'h06, 4);
    check("t2_digit_E", digit, 14);
    hold(7'h21, 4);
    check("t2_digit_d", digit, 13);
    check("t2_dv_pulses", n_dv - s_dv, 3);
    check("t2_no_seqerr", n_se - s_se, 0);

    hold(7'h7F, 3);
    check("t3_blank_unlock", locked, 0);
    check("t3_blank_digit", digit, 13);
    snap();
    hold(7'h0E, 4);
    check("t3_first_no_seq", n_se - s_se, 0);
    hold(7'h79, 4);
    check("t3_jump_seqerr", n_se - s_se, SEQ_ON);
    check("t3_jump_errcnt", err_count, SEQ_ON);
    check("t3_jump_digit", digit, 1);
    check("t3_jump_locked", locked, 1);
    snap();
    hold(7'h40, 4);
    hold(7'h0E, 4);
    check("t3_wrap_no_seq", n_se - s_se, 0);
    check("t3_wrap_digit", digit, 15);

    hold(7'h7F, 1);
    clear_err = 1'b1;
    hold(7'h7F, 1);
    clear_err = 1'b0;
    hold(7'h7F, 2);
    check("t4_cleared", err_count, 0);
    hold(7'h30, 4);
    check("t4_digit3", digit, 3);
    snap();
    hold(7'h7B, 1);
    hold(7'h30, 4);
    check("t4_glitch_perr", n_pe - s_pe, 0);
    check("t4_glitch_dv", n_dv - s_dv, 0);
    check("t4_glitch_digit", digit, 3);
    hold(7'h7B, 3);
    check("t4_illegal_perr", n_pe - s_pe, 1);
    check("t4_illegal_locked", locked, 0);
    check("t4_illegal_errcnt", err_count, 1);
    check("t4_illegal_digit", digit, 3);

    clear_err = 1'b1;
    hold(7'h7B, 1);
    clear_err = 1'b0;
    check("t5_cleared_w2", w2_err_count, 0);
    snap();
    hold(7'h7D, 3);
    hold(7'h01, 3);
    hold(7'h7E, 3);
    check("t5_w2_three", w2_err_count, 3);
    hold(7'h77, 3);
    hold(7'h7B, 3);
    check("t5_w2_saturate", w2_err_count, 3);
    check("t5_w8_five", err_count, 5);
    check("t5_perr_pulses", n_pe - s_pe, 5);
    hold(7'h3F, 1);
    clear_err = 1'b1;
    hold(7'h3F, 1);
    clear_err = 1'b0;
    check("t5_clr_pulse", w2_pattern_err, 1);
    check("t5_clr_w2", w2_err_count, 0);
    check("t5_clr_w8", err_count, 0);
    hold(7'h3F, 2);
    check("t5_after_clr", err_count, 0);

    hold(7'h12, 1);
    reset = 1'b0;
    #1;
    check("t6_rst_digit", digit, 0);
    check("t6_rst_locked", locked, 0);
    check("t6_rst_errcnt", err_count, 0);
    check("t6_rst_pulses", {digit_valid, pattern_err, seq_err}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    snap();
    hold(7'h12, 3);
    check("t6_dv_pulse", n_dv - s_dv, 1);
    check("t6_digit5", digit, 5);
    check("t6_no_seq", n_se - s_se, 0);
    check("t6_locked", locked, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_decode_monitor.md
Name: seg7_decode_monitor

Overview:
- Receive-side companion to the team's hex counter with 7-segment output: samples a 7-segment drive bus and decodes it back to a 4-bit hex digit.
- Qualifies patterns through a stability filter and flags illegal patterns.
- Optionally checks that successive digits follow a modulo-16 down-count sequence.
- Used on-chip as a self-check monitor or in benches as a display scoreboard.

Parameters:
- STABLE_CYCLES, 2: consecutive identical samples required before a pattern is accepted; legal range 1..15.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- seg_in  input  7  segment bus {g,f,e,d,c,b,a}, active-low (0 = lit).
- clear_err  input  1  synchronous clear of err_count.
- digit  output  4  last legally decoded hex value.
- digit_valid  output  1  one-cycle pulse when a new legal pattern is accepted.
- pattern_err  output  1  one-cycle pulse when an illegal pattern is accepted.
- seq_err  output  1  one-cycle pulse on a down-sequence violation.
- locked  output  1  high while a reference digit is held for sequence checking.
- err_count  output  ERR_W  saturating count of pattern_err plus seq_err events.

Behaviour:
- Reset (reset=0, asynchronous): digit=0, digit_valid=0, pattern_err=0, seq_err=0, locked=0, err_count=0, sample register=7'h7F, run counter=0, accepted flag=0.
- All outputs are registered.
- Decode table, seg_in to digit:
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F
- 7F is BLANK.
- Every other code is ILLEGAL.
- Stability filter, every clock:
  - samp <= seg_in.
  - If seg_in != samp: run <= 1 and the accepted flag clears.
  - Otherwise run increments, saturating at STABLE_CYCLES.
- Accept event: when run reaches STABLE_CYCLES and the accepted flag is clear. The accepted flag then sets, so only one accept is made per stable run.
- Latency: a pattern first sampled at edge n is accepted at edge n+STABLE_CYCLES-1. The response pulses are visible for the single cycle after that edge.
- On accept of a legal code: digit <= decoded value, digit_valid=1, locked <= 1.
- On accept of BLANK: no pulse and digit holds. locked <= 0 and no error is counted.
- On accept of an ILLEGAL code: pattern_err=1, digit holds, locked <= 0, err_count increments.
- A glitch shorter than STABLE_CYCLES is never accepted and produces no pulse. The value already accepted stays in effect.
- err_count saturates at all-ones; it never wraps.
- clear_err has priority over an increment in the same cycle: the count goes to 0. The error pulse is still emitted.
- Reset mid-run returns the block to reset state immediately. The first accept after reset is never a sequence error.

Optional Feature:
- Macro: SEG7_SEQ_CHECK_EN.
- Defined:
  - On a legal accept with locked=1, expected = (digit - 1) mod 16.
  - If the decoded value equals expected, or equals digit (display held), the accept passes.
  - Any other value asserts seq_err for one cycle and increments err_count.
  - digit still updates and locked stays 1.
  - Wrap 0->F is legal.
- Not defined:
  - seq_err is tied to 0 and err_count counts pattern_err only.
  - locked remains functional.

Test Plan:
- Reset, then seg_in=40 held 3 cycles (STABLE_CYCLES=2) -> exactly one digit_valid pulse, digit=0, locked=1, err_count=0.
- Sequence 40, 0E, 06, 21, each held 4 cycles, macro defined -> digit goes 0, F, E, d; four digit_valid pulses; seq_err never asserts.
- Jump 0E to 79 (F->1) with macro defined -> seq_err pulse, err_count=1, digit=1. With macro undefined: no pulse, err_count=0.
- Hold 30, inject 7B for 1 cycle, return to 30 -> no pattern_err, no digit_valid, digit stays 3. Then hold 7B for 3 cycles -> pattern_err pulse, locked=0, err_count=1.
- ERR_W=2, apply 5 illegal patterns -> err_count saturates at 3. Assert clear_err together with a 6th error -> err_count=0 and the pattern_err pulse is still emitted.
- Hold 12, drop reset mid-run for 1 cycle, release -> all outputs 0 during reset. After STABLE_CYCLES: digit_valid with digit=5 and no seq_err.
